rotate_collect: RTL and testbench

//  Downstream collector for the right rotator. Snoops the rotator's din/amount

---
 rtl/rotate_pkg.sv | 22 ++
 rtl/rotate_fifo.sv | 80 ++++++++
 rtl/rotate_collect.sv | 136 +++++++++++++
 tb/tb_rotate_collect.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// ---------------------------------------------------------------------------
// rotate_pkg
// Shared definitions for the right-rotator collector slice.
//   ROT_W  : default data width of the rotator datapath
//   ROT_AW : default amount width (log2 ROT_W)
//   rotr() : reference right-rotate used by the optional result checker
// ---------------------------------------------------------------------------
package rotate_pkg;

  localparam int ROT_W  = 4;
  localparam int ROT_AW = 2;

  // Rotating right is a logical shift of the word concatenated with itself.
  // The low half of the shifted result is the rotated word.
  function automatic logic [ROT_W-1:0] rotr(input logic [ROT_W-1:0]  data,
                                            input logic [ROT_AW-1:0] amt);
    logic [2*ROT_W-1:0] doubled;
    doubled = {data, data} >> amt;
    return doubled[ROT_W-1:0];
  endfunction

endpackage

// File: rtl/rotate_fifo.sv
// ---------------------------------------------------------------------------
// rotate_fifo
// Small synchronous FIFO holding rotated words for the collector.
// Ports:
//   clock     : single clock, all state on posedge
//   reset_n   : synchronous active-low reset (pointers and head register)
//   push      : write push_data at the tail (caller guarantees room, or a
//               simultaneous pop when full)
//   push_data : word to store
//   pop       : remove the head (caller guarantees the FIFO is not empty)
//   head_data : registered copy of the head word; holds when empty
//   empty     : no words stored
//   full      : DEPTH words stored
// Pointers carry one extra wrap bit so full and empty are distinguished by a
// plain compare and wrap-around needs no special casing.
// ---------------------------------------------------------------------------
module rotate_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [W-1:0] head_q, head_d;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_data = head_q;

  // The head register looks at the storage as it will be after this edge,
  // so a word written into the slot that becomes the new head (push into an
  // empty FIFO, or pop down to a single just-written entry) is picked up
  // immediately. When the FIFO drains the last head value is kept.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    head_d   = head_q;
    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (rd_ptr_d != wr_ptr_d) begin
      head_d = mem_d[rd_ptr_d[PW-1:0]];
    end
  end

  // Storage itself needs no reset; only pointers and the visible head do.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/rotate_collect.sv
// ---------------------------------------------------------------------------
// rotate_collect
// Downstream collector for the right rotator. A valid bit follows each issued
// word through the rotator's two-edge pipeline; the rotated result is pushed
// into a FIFO and handed on over valid/ready. Words arriving at a full FIFO
// with no pop are dropped and counted.
// Ports:
//   clock, reset_n       : clock and synchronous active-low reset
//   in_valid             : rot_din carries a real word this cycle
//   rot_din, rot_amount  : snooped rotator inputs (amount follows din by one)
//   rot_dout             : rotator output, pushed two edges after issue
//   out_valid/out_ready  : FIFO head handshake, out_data is the head word
//   full                 : FIFO holds DEPTH words
//   ovf, drop_cnt        : sticky drop flag and saturating drop counter
//   chk_err              : sticky rotator-result mismatch flag
// Build option: define ROTATE_COLLECT_CHK_EN to include the result checker;
// otherwise chk_err is tied low and no checker logic exists.
// ---------------------------------------------------------------------------
module rotate_collect
  import rotate_pkg::*;
#(
  parameter int W     = ROT_W,
  parameter int AW    = ROT_AW,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [W-1:0]  rot_din,
  input  logic [AW-1:0] rot_amount,
  input  logic [W-1:0]  rot_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          full,
  output logic          ovf,
  output logic [CW-1:0] drop_cnt,
  output logic          chk_err
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          drop;

  // A pop frees a slot in the same edge, so a full FIFO still accepts the
  // arriving word when the consumer takes the head at the same time.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = v2_q && (!full || pop);
  assign drop      = v2_q && full && !pop;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;

  rotate_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (rot_dout),
    .pop       (pop),
    .head_data (out_data),
    .empty     (fifo_empty),
    .full      (full)
  );

  // The valid pipe advances every cycle so bubbles flow through untouched;
  // the drop counter stops at all-ones instead of wrapping.
  always_comb begin
    v1_d       = in_valid;
    v2_d       = v1_q;
    ovf_d      = ovf_q || drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef ROTATE_COLLECT_CHK_EN
  logic [W-1:0] din_q, din_d;
  logic [W-1:0] exp_q, exp_d;
  logic         chk_err_q, chk_err_d;

  // The checker mirrors the rotator's timing: din captured with the issue,
  // expected result formed when the amount arrives, compared at push time.
  // Dropped words are checked too, since only v2 qualifies the compare.
  always_comb begin
    din_d     = rot_din;
    exp_d     = rotr(din_q, rot_amount);
    chk_err_d = chk_err_q || (v2_q && (rot_dout != exp_q));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      din_q     <= '0;
      exp_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      din_q     <= din_d;
      exp_q     <= exp_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  // Without the checker the snooped din/amount are not needed.
  logic unused_chk_inputs;
  assign unused_chk_inputs = ^{rot_din, rot_amount};
  assign chk_err           = 1'b0;
`endif

endmodule

// File: tb/tb_rotate_collect.sv
// ---------------------------------------------------------------------------
// tb_rotate_collect
// Bench for rotate_collect with a behavioural rotator in the loop. Directed
// table rows cover single-word latency, fill/overflow and pop+push when full;
// hand-written sequences cover the wrapping stream, mid-stream reset, drop
// counter saturation and a corrupted rotator result; a random phase follows.
// A queue-based reference model tracks the expected FIFO contents and flags.
// ---------------------------------------------------------------------------
module tb_rotate_collect;

  localparam int W     = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [W-1:0]  rot_din;
  logic [AW-1:0] rot_amount;
  logic [W-1:0]  rot_dout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          full;
  logic          ovf;
  logic [CW-1:0] drop_cnt;
  logic          chk_err;
  logic          corrupt_in;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rotate_collect #(
    .W     (W),
    .AW    (AW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .rot_din    (rot_din),
    .rot_amount (rot_amount),
    .rot_dout   (rot_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .full       (full),
    .ovf        (ovf),
    .drop_cnt   (drop_cnt),
    .chk_err    (chk_err)
  );

  // Plain arithmetic rotate right on a 4-bit value.
  function automatic logic [W-1:0] refRotate(input logic [W-1:0] d, input int a);
    int v;
    v = int'(d);
    v = ((v >> a) | (v << (W - a))) & ((1 << W) - 1);
    return v[W-1:0];
  endfunction

  // Behavioural rotator: din registered at issue, result registered when the
  // amount arrives one cycle later. A corrupt tag forces its result to zero.
  logic [W-1:0] rot_stage_din  = '0;
  logic [W-1:0] rot_stage_dout = '0;
  logic         corr1 = 1'b0;
  logic         corr2 = 1'b0;

  always @(posedge clock) begin
    rot_stage_din  <= rot_din;
    rot_stage_dout <= refRotate(rot_stage_din, int'(rot_amount));
    corr1          <= corrupt_in;
    corr2          <= corr1;
  end

  assign rot_dout = corr2 ? '0 : rot_stage_dout;

  // Reference model state.
  logic [W-1:0] modelQ[$];
  logic [W-1:0] modelHead;
  bit           modelOvf;
  int           modelDrop;
  bit           modelChk;
  bit           s1Valid, s1Corrupt, s2Valid, s2Corrupt;
  logic [W-1:0] s1Din, s2Din;
  int           s2Amt;

  task automatic modelEdge(input logic iv, input logic [W-1:0] din,
                           input logic [AW-1:0] amt, input logic rdy,
                           input logic rstn, input logic corr);
    logic [W-1:0] arriving;
    if (!rstn) begin
      modelQ.delete();
      modelHead = '0;
      modelOvf  = 0;
      modelDrop = 0;
      modelChk  = 0;
      s1Valid   = 0;
      s2Valid   = 0;
    end else begin
      if (modelQ.size() > 0 && rdy) void'(modelQ.pop_front());
      if (s2Valid) begin
        arriving = s2Corrupt ? '0 : refRotate(s2Din, s2Amt);
`ifdef ROTATE_COLLECT_CHK_EN
        if (arriving != refRotate(s2Din, s2Amt)) modelChk = 1;
`endif
        if (modelQ.size() < DEPTH) modelQ.push_back(arriving);
        else begin
          modelOvf = 1;
          if (modelDrop < DROP_MAX) modelDrop++;
        end
      end
      s2Valid   = s1Valid;
      s2Din     = s1Din;
      s2Corrupt = s1Corrupt;
      s2Amt     = int'(amt);
      s1Valid   = iv;
      s1Din     = din;
      s1Corrupt = corr;
      if (modelQ.size() > 0) modelHead = modelQ[0];
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".out_valid"}, int'(out_valid), (modelQ.size() > 0) ? 1 : 0);
    checkValue({tag, ".out_data"},  int'(out_data),  int'(modelHead));
    checkValue({tag, ".full"},      int'(full),      (modelQ.size() == DEPTH) ? 1 : 0);
    checkValue({tag, ".ovf"},       int'(ovf),       int'(modelOvf));
    checkValue({tag, ".drop_cnt"},  int'(drop_cnt),  modelDrop);
    checkValue({tag, ".chk_err"},   int'(chk_err),   int'(modelChk));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle.
  task automatic applyStimulus(input logic iv, input logic [W-1:0] din,
                               input logic [AW-1:0] amt, input logic rdy,
                               input logic rstn, input logic corr);
    in_valid   = iv;
    rot_din    = din;
    rot_amount = amt;
    out_ready  = rdy;
    reset_n    = rstn;
    corrupt_in = corr;
    @(posedge clock);
    modelEdge(iv, din, amt, rdy, rstn, corr);
    #1;
  endtask

  typedef struct {
    logic          iv;
    logic [W-1:0]  din;
    logic [AW-1:0] amt;
    logic          rdy;
    logic          expValid;
    logic [W-1:0]  expData;
    logic          expFull;
    logic          expOvf;
    int            expDrop;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic iv, input logic [W-1:0] din, input logic [AW-1:0] amt,
                        input logic rdy, input logic ev, input logic [W-1:0] ed,
                        input logic ef, input logic eo, input int edrop);
    vec_t v;
    v.iv = iv; v.din = din; v.amt = amt; v.rdy = rdy;
    v.expValid = ev; v.expData = ed; v.expFull = ef; v.expOvf = eo; v.expDrop = edrop;
    vecs.push_back(v);
  endtask

  initial begin
    int dropBefore;

    // Single word: 0001 rotated by 1 shows up as 1000 three edges later.
    addVec(1, 4'b0001, 2'd0, 0,  0, 4'b0000, 0, 0, 0);
    addVec(0, 4'b0000, 2'd1, 0,  0, 4'b0000, 0, 0, 0);
    addVec(0, 4'b0000, 2'd0, 0,  1, 4'b1000, 0, 0, 0);
    addVec(0, 4'b0000, 2'd0, 1,  0, 4'b1000, 0, 0, 0);
    // Five back-to-back words with no consumer: four fill, the fifth drops.
    addVec(1, 4'b0011, 2'd0, 0,  0, 4'b1000, 0, 0, 0);
    addVec(1, 4'b0101, 2'd0, 0,  0, 4'b1000, 0, 0, 0);
    addVec(1, 4'b0001, 2'd1, 0,  1, 4'b0011, 0, 0, 0);
    addVec(1, 4'b0111, 2'd2, 0,  1, 4'b0011, 0, 0, 0);
    addVec(1, 4'b1001, 2'd3, 0,  1, 4'b0011, 0, 0, 0);
    addVec(0, 4'b0000, 2'd1, 0,  1, 4'b0011, 1, 0, 0);
    addVec(0, 4'b0000, 2'd0, 0,  1, 4'b0011, 1, 1, 1);
    // Full FIFO: pop and arrival on the same edge, then drain in order.
    addVec(1, 4'b0110, 2'd0, 0,  1, 4'b0011, 1, 1, 1);
    addVec(0, 4'b0000, 2'd2, 0,  1, 4'b0011, 1, 1, 1);
    addVec(0, 4'b0000, 2'd0, 1,  1, 4'b1010, 1, 1, 1);
    addVec(0, 4'b0000, 2'd0, 1,  1, 4'b0100, 0, 1, 1);
    addVec(0, 4'b0000, 2'd0, 1,  1, 4'b1110, 0, 1, 1);
    addVec(0, 4'b0000, 2'd0, 1,  1, 4'b1001, 0, 1, 1);
    addVec(0, 4'b0000, 2'd0, 1,  0, 4'b1001, 0, 1, 1);

    $display("[TB] reset");
    applyStimulus(0, '0, '0, 0, 0, 0);
    applyStimulus(0, '0, '0, 0, 0, 0);
    checkOutput("reset");

    $display("[TB] directed table");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].iv, vecs[i].din, vecs[i].amt, vecs[i].rdy, 1, 0);
      checkOutput($sformatf("vec%0d", i));
      checkValue($sformatf("vec%0d.tbl_valid", i), int'(out_valid), int'(vecs[i].expValid));
      checkValue($sformatf("vec%0d.tbl_data", i),  int'(out_data),  int'(vecs[i].expData));
      checkValue($sformatf("vec%0d.tbl_full", i),  int'(full),      int'(vecs[i].expFull));
      checkValue($sformatf("vec%0d.tbl_ovf", i),   int'(ovf),       int'(vecs[i].expOvf));
      checkValue($sformatf("vec%0d.tbl_drop", i),  int'(drop_cnt),  vecs[i].expDrop);
    end

    $display("[TB] stream across pointer wrap");
    dropBefore = int'(drop_cnt);
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2) == 0, 4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)),
                    (i % 4) < 2, 1, 0);
      checkOutput($sformatf("stream%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, '0, 2'($urandom_range(0, 3)), 1, 1, 0);
      checkOutput($sformatf("drain%0d", i));
    end
    checkValue("stream.empty", int'(out_valid), 0);
    checkValue("stream.noloss", int'(drop_cnt), dropBefore);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)), 0, 1, 0);
      checkOutput($sformatf("fill%0d", i));
    end
    applyStimulus(0, '0, 2'd1, 1, 0, 0);
    checkOutput("midreset");
    checkValue("midreset.out_valid", int'(out_valid), 0);
    checkValue("midreset.ovf", int'(ovf), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 2'd0, 1, 1, 0);
      checkOutput($sformatf("postreset%0d", i));
    end

    $display("[TB] corrupted rotator result");
    applyStimulus(1, 4'b0011, 2'd0, 0, 1, 1);
    applyStimulus(0, 4'b0000, 2'd2, 0, 1, 0);
    applyStimulus(0, 4'b0000, 2'd0, 0, 1, 0);
    checkOutput("corrupt.e2");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 2'd0, 1, 1, 0);
      checkOutput($sformatf("corrupt.hold%0d", i));
    end

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 270; i++) begin
      applyStimulus(1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 0, 1, 0);
      if ((i % 16) == 0 || i > 260) checkOutput($sformatf("sat%0d", i));
    end
    checkValue("sat.drop_cnt", int'(drop_cnt), DROP_MAX);
    applyStimulus(0, '0, '0, 0, 0, 0);
    checkOutput("sat.reset");

    $display("[TB] random stimulus");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 99) != 0, $urandom_range(0, 15) == 0);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
